// File: rtl/input_debounce.sv
// Multi-channel button/switch debouncer: 2-flop synchroniser, stable-count acceptance,
// registered edge pulses, optional long-press detection and sticky press flags with irq.
module input_debounce #(
  parameter int unsigned         CHANNELS        = 4,
  parameter int unsigned         DEBOUNCE_CYCLES = 50000,
  parameter int unsigned         LONG_CYCLES     = 0,
  parameter int unsigned         CNT_W           = 24,
  parameter logic [CHANNELS-1:0] POLARITY        = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] clean_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic [CHANNELS-1:0] pending,
  output logic                irq
);

  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] clean_q, rise_q, fall_q, pend_q;
  logic [CHANNELS-1:0] accept;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Any cycle where the synchronised input agrees with the accepted level wipes the count.
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      accept[i] = 1'b0;
      cnt_d[i]  = cnt_q[i];
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DebLast) begin
        accept[i] = 1'b1;
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw_in ^ POLARITY;
      sync2_q <= sync1_q;
      clean_q <= clean_q ^ accept;
      rise_q  <= accept & sync2_q;
      fall_q  <= accept & ~sync2_q;
      // A new press wins over a coincident clear so no event is lost.
      pend_q  <= (pend_q & ~clr) | rise_q;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  if (LONG_CYCLES == 0) begin : g_no_long
    assign long_pulse = '0;
  end else begin : g_long
    localparam logic [CNT_W-1:0] LongMax  = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0]    hold_q [CHANNELS];
    logic [CNT_W-1:0]    hold_d [CHANNELS];
    logic [CHANNELS-1:0] long_q, long_d;

    // Hold count saturates at LongMax so the pulse fires once per press.
    always_comb begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        hold_d[i] = hold_q[i];
        long_d[i] = 1'b0;
        if (!clean_q[i]) begin
          hold_d[i] = '0;
        end else if (hold_q[i] != LongMax) begin
          hold_d[i] = hold_q[i] + CNT_W'(1);
          long_d[i] = (hold_q[i] == LongLast);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        long_q <= '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
          hold_q[i] <= '0;
        end
      end else begin
        long_q <= long_d;
        for (int i = 0; i < int'(CHANNELS); i++) begin
          hold_q[i] <= hold_d[i];
        end
      end
    end

    assign long_pulse = long_q;
  end

  assign clean_out  = clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign pending    = pend_q;
  assign irq        = |pend_q;

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: expected pulse events are queued with their cycle
// and matched against pulses observed on the DUT; levels are checked inline.
module tb_input_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] raw_in = 2'b00;
  logic [1:0] clr = 2'b00;

  logic [1:0] clean_out, rise_pulse, fall_pulse, long_pulse, pending;
  logic       irq;
  logic [1:0] clean_p, rise_p, fall_p, long_p, pending_p;
  logic       irq_p;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_q[$];
  int obs_q[$];

  input_debounce #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .CNT_W(8), .POLARITY(2'b00)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .clr(clr), .clean_out(clean_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .long_pulse(long_pulse),
    .pending(pending), .irq(irq)
  );

  input_debounce #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .CNT_W(8), .POLARITY(2'b10)
  ) dut_p (
    .clk(clk), .rst(rst), .raw_in(raw_in), .clr(clr), .clean_out(clean_p),
    .rise_pulse(rise_p), .fall_pulse(fall_p), .long_pulse(long_p),
    .pending(pending_p), .irq(irq_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event code: cycle, kind (0 rise, 1 fall, 2 long), channel.
  function automatic int ev(input int c, input int kind, input int ch);
    return (c << 4) | (kind << 2) | ch;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        if (rise_pulse[c]) obs_q.push_back(ev(cyc, 0, c));
        if (fall_pulse[c]) obs_q.push_back(ev(cyc, 1, c));
        if (long_pulse[c]) obs_q.push_back(ev(cyc, 2, c));
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({clean_out, rise_pulse, fall_pulse, long_pulse, pending, irq} !== 11'd0) begin
      fails++;
      $display("FAIL reset_main: got %b expected 0",
               {clean_out, rise_pulse, fall_pulse, long_pulse, pending, irq});
    end
    tests++;
    if ({clean_p, rise_p, fall_p, long_p, pending_p, irq_p} !== 11'd0) begin
      fails++;
      $display("FAIL reset_pol: got %b expected 0",
               {clean_p, rise_p, fall_p, long_p, pending_p, irq_p});
    end
    rst = 1'b0;
  endtask

  task automatic test_press();
    int c0, e, o;
    @(negedge clk);
    c0 = cyc;
    raw_in[0] = 1'b1;
    exp_q.push_back(ev(c0 + 6, 0, 0));
    repeat (5) @(negedge clk);
    tests++;
    if (clean_out[0] !== 1'b0) begin
      fails++; $display("FAIL press_early: clean_out[0]=%b expected 0", clean_out[0]);
    end
    @(negedge clk);
    tests++;
    if (clean_out[0] !== 1'b1) begin
      fails++; $display("FAIL press_accept: clean_out[0]=%b expected 1", clean_out[0]);
    end
    @(negedge clk);
    tests++;
    if ({rise_pulse[0], pending, irq} !== 4'b0011) begin
      fails++; $display("FAIL press_pending: rise,pending,irq=%b expected 0011",
                        {rise_pulse[0], pending, irq});
    end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    tests++;
    if ({pending, irq} !== 3'b000) begin
      fails++; $display("FAIL press_clr: pending,irq=%b expected 000", {pending, irq});
    end
    raw_in[0] = 1'b0;
    exp_q.push_back(ev(cyc + 6, 1, 0));
    repeat (8) @(negedge clk);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL press_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL press_event: got %0h expected %0h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    int e, o;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      raw_in[0] = (i < 20) ? ~i[1] : 1'b0;
      tests++;
      if ({clean_out[0], rise_pulse[0], fall_pulse[0]} !== 3'b000) begin
        fails++; $display("FAIL glitch_cycle%0d: clean,rise,fall=%b expected 000", i,
                          {clean_out[0], rise_pulse[0], fall_pulse[0]});
      end
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL glitch_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL glitch_event: got %0h expected %0h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_long();
    int c0, e, o;
    @(negedge clk);
    c0 = cyc;
    raw_in[1] = 1'b1;
    exp_q.push_back(ev(c0 + 6, 0, 1));
    exp_q.push_back(ev(c0 + 16, 2, 1));
    repeat (30) @(negedge clk);
    raw_in[1] = 1'b0;
    exp_q.push_back(ev(c0 + 36, 1, 1));
    repeat (5) @(negedge clk);
    tests++;
    if (clean_out[1] !== 1'b1) begin
      fails++; $display("FAIL long_held: clean_out[1]=%b expected 1", clean_out[1]);
    end
    @(negedge clk);
    tests++;
    if (clean_out[1] !== 1'b0) begin
      fails++; $display("FAIL long_release: clean_out[1]=%b expected 0", clean_out[1]);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL long_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL long_event: got %0h expected %0h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clr_collide();
    int c0, e, o;
    @(negedge clk);
    c0 = cyc;
    raw_in[0] = 1'b1;
    exp_q.push_back(ev(c0 + 6, 0, 0));
    repeat (6) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    tests++;
    if (pending[0] !== 1'b1) begin
      fails++; $display("FAIL clr_collide: pending[0]=%b expected 1", pending[0]);
    end
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    tests++;
    if ({pending, irq} !== 3'b101) begin
      fails++; $display("FAIL clr_after: pending,irq=%b expected 101", {pending, irq});
    end
    raw_in[0] = 1'b0;
    exp_q.push_back(ev(cyc + 6, 1, 0));
    repeat (8) @(negedge clk);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL clr_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL clr_event: got %0h expected %0h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midcount();
    int q, e, o;
    @(negedge clk);
    raw_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({clean_out, rise_pulse, fall_pulse, long_pulse, pending, irq} !== 11'd0) begin
      fails++; $display("FAIL midreset_main: got %b expected 0",
                        {clean_out, rise_pulse, fall_pulse, long_pulse, pending, irq});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q = cyc;
    exp_q.push_back(ev(q + 6, 0, 0));
    repeat (5) @(negedge clk);
    tests++;
    if (clean_out[0] !== 1'b0) begin
      fails++; $display("FAIL midreset_early: clean_out[0]=%b expected 0", clean_out[0]);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({clean_out, pending} !== 4'b0101) begin
      fails++; $display("FAIL midreset_after: clean,pending=%b expected 0101", {clean_out, pending});
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL midreset_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL midreset_event: got %0h expected %0h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_polarity();
    int q, e, o;
    @(negedge clk);
    rst = 1'b1;
    raw_in = 2'b10;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q = cyc;
    exp_q.push_back(ev(q + 6, 0, 1));
    exp_q.push_back(ev(q + 16, 2, 1));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests++;
      if ({clean_p, rise_p, fall_p, long_p, pending_p, irq_p} !== 11'd0) begin
        fails++; $display("FAIL polarity_cycle%0d: got %b expected 0", i,
                          {clean_p, rise_p, fall_p, long_p, pending_p, irq_p});
      end
    end
    tests++;
    if (clean_out !== 2'b10) begin
      fails++; $display("FAIL polarity_main: clean_out=%b expected 10", clean_out);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL polarity_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL polarity_event: got %0h expected %0h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simultaneous();
    int c0, e, o;
    @(negedge clk);
    c0 = cyc;
    raw_in = 2'b01;
    exp_q.push_back(ev(c0 + 6, 0, 0));
    exp_q.push_back(ev(c0 + 6, 1, 1));
    repeat (6) @(negedge clk);
    tests++;
    if ({clean_out, rise_pulse, fall_pulse} !== 6'b010110) begin
      fails++; $display("FAIL simul_main: clean,rise,fall=%b expected 010110",
                        {clean_out, rise_pulse, fall_pulse});
    end
    tests++;
    if ({clean_p, rise_p} !== 4'b1111) begin
      fails++; $display("FAIL simul_pol: clean,rise=%b expected 1111", {clean_p, rise_p});
    end
    repeat (2) @(negedge clk);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL simul_events: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o !== e) begin fails++; $display("FAIL simul_event: got %0h expected %0h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_long();
    test_clr_collide();
    test_reset_midcount();
    test_polarity();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
